// File: rtl/instr_queue_pkg.sv
// Shared CPU definitions: instruction width, NOP encoding, opcodes and field layout.
// Imported by the instruction queue and by the decode stage that consumes it.
package instr_queue_pkg;

   localparam int INSTR_WIDTH = 8;

   localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 8'h00;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_INC = 3'b011
   } opcode_e;

   localparam int MODE_BIT   = 7;
   localparam int OPCODE_MSB = 6;
   localparam int OPCODE_LSB = 4;
   localparam int RD_MSB     = 3;
   localparam int RD_LSB     = 2;
   localparam int RS2_MSB    = 1;
   localparam int RS2_LSB    = 0;

   typedef struct packed {
      logic       mode;
      logic [2:0] opcode;
      logic [1:0] rd;
      logic [1:0] rs2;
   } instr_t;

   function automatic logic [2:0] instr_opcode(input logic [INSTR_WIDTH-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

   // Only ADD and INC write the register file; everything else behaves as a no-op.
   function automatic logic instr_writes_reg(input logic [INSTR_WIDTH-1:0] instr);
      logic wr_s;
      case (instr_opcode(instr))
         OP_ADD:  wr_s = 1'b1;
         OP_INC:  wr_s = 1'b1;
         default: wr_s = 1'b0;
      endcase
      return wr_s;
   endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Handshake bundle between the switch/button front end, the instruction queue
// and the decode stage.
interface instr_queue_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             load;
   logic [WIDTH-1:0] switches_state;
   logic             stall;
   logic [WIDTH-1:0] if_id_reg;
   logic             if_id_valid;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             overflow;

   modport master (
      output load, switches_state, stall,
      input  if_id_reg, if_id_valid, count, full, empty, overflow
   );

   modport slave (
      input  load, switches_state, stall,
      output if_id_reg, if_id_valid, count, full, empty, overflow
   );

endinterface

// File: rtl/instr_queue_edge_detect.sv
// Rising-edge detector for debounced push-buttons; one rise pulse per press.
// The history flop resets to INIT so a button held through reset is not seen as a press.
module edge_detect #(
   parameter logic INIT = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic in,
   output logic rise
);

   logic in_q_r;

   // Previous-cycle sample of the button level.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         in_q_r <= INIT;
      end else begin
         in_q_r <= in;
      end
   end

   assign rise = in & ~in_q_r;

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between the switch-loaded front end and the IF/ID register.
// Pushes come from load-button presses; pops feed decode unless it stalls.
module instr_queue
   import instr_queue_pkg::*;
#(
   parameter int               DEPTH  = 4,
   parameter int               WIDTH  = INSTR_WIDTH,
   parameter logic [WIDTH-1:0] BUBBLE = INSTR_NOP
) (
   input  logic          clk,
   input  logic          resetn,
   instr_queue_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic [WIDTH-1:0] if_id_reg_r;
   logic             if_id_valid_r;
   logic             overflow_r;

   logic             push_req_s;
   logic             pop_req_s;
   logic             push_ok_s;
   logic             drop_s;
   logic             full_s;
   logic             empty_s;

   edge_detect #(.INIT(1'b1)) u_load_edge (
      .clk    (clk),
      .resetn (resetn),
      .in     (bus.load),
      .rise   (push_req_s)
   );

   // Status depends on the count register only, never on this cycle's inputs.
   assign full_s  = (count_r == CNT_W'(DEPTH));
   assign empty_s = (count_r == {CNT_W{1'b0}});

   // A full queue still accepts a push when a pop frees the slot on the same edge.
   assign pop_req_s = ~bus.stall & ~empty_s;
   assign push_ok_s = push_req_s & (~full_s | pop_req_s);
   assign drop_s    = push_req_s & full_s & ~pop_req_s;

   // Occupancy update.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_ok_s, pop_req_s})
         2'b10:   count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         2'b01:   count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage is not reset; stale entries are never read before being written.
   always_ff @(posedge clk) begin
      if (resetn && push_ok_s) begin
         mem_r[wr_ptr_r] <= bus.switches_state;
      end
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop_req_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         count_r <= count_nxt_s;
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // IF/ID register: dequeued entry, bubble when starved, hold while stalled.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         if_id_reg_r   <= BUBBLE;
         if_id_valid_r <= 1'b0;
      end else if (pop_req_s) begin
         if_id_reg_r   <= mem_r[rd_ptr_r];
         if_id_valid_r <= 1'b1;
      end else if (!bus.stall) begin
         if_id_reg_r   <= BUBBLE;
         if_id_valid_r <= 1'b0;
      end else begin
         if_id_reg_r   <= if_id_reg_r;
         if_id_valid_r <= if_id_valid_r;
      end
   end

   assign bus.if_id_reg   = if_id_reg_r;
   assign bus.if_id_valid = if_id_valid_r;
   assign bus.count       = count_r;
   assign bus.full        = full_s;
   assign bus.empty       = empty_s;
   assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_instr_queue;
   import instr_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   instr_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BUBBLE(INSTR_NOP)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: FIFO of accepted instructions plus the observable registers.
   logic [7:0] mq [$];
   logic       m_load_q = 1'b1;
   logic [7:0] m_ifid   = 8'h00;
   logic       m_valid  = 1'b0;
   logic       m_ovf    = 1'b0;

   typedef struct {
      logic       rn;
      logic       ld;
      logic [7:0] sw;
      logic       st;
      logic [7:0] e_ifid;
      logic       e_valid;
      int         e_cnt;
      logic       e_full;
      logic       e_empty;
      logic       e_ovf;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic l, input logic [7:0] sw, input logic st);
      bit push;
      bit pop;
      if (!r) begin
         mq.delete();
         m_ifid   = INSTR_NOP;
         m_valid  = 1'b0;
         m_ovf    = 1'b0;
         m_load_q = 1'b1;
      end else begin
         push     = l && !m_load_q;
         pop      = !st && (mq.size() != 0);
         m_load_q = l;
         if (pop) begin
            m_ifid  = mq.pop_front();
            m_valid = 1'b1;
         end else if (!st) begin
            m_ifid  = INSTR_NOP;
            m_valid = 1'b0;
         end
         if (push) begin
            if (mq.size() < DEPTH) mq.push_back(sw);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic step(input logic r, input logic l, input logic [7:0] sw, input logic st);
      resetn             = r;
      bus.load           = l;
      bus.switches_state = sw;
      bus.stall          = st;
      @(posedge clk);
      #1;
      model_update(r, l, sw, st);
      chk("model if_id_reg", int'(bus.if_id_reg), int'(m_ifid));
      chk("model if_id_valid", int'(bus.if_id_valid), int'(m_valid));
      chk("model count", int'(bus.count), mq.size());
      chk("model full", int'(bus.full), int'(mq.size() == DEPTH));
      chk("model empty", int'(bus.empty), int'(mq.size() == 0));
      chk("model overflow", int'(bus.overflow), int'(m_ovf));
   endtask

   function automatic void add(input logic rn, input logic ld, input logic [7:0] sw, input logic st,
                               input logic [7:0] e_ifid, input logic e_valid, input int e_cnt,
                               input logic e_full, input logic e_empty, input logic e_ovf);
      vec_t v;
      v = '{rn, ld, sw, st, e_ifid, e_valid, e_cnt, e_full, e_empty, e_ovf};
      tbl.push_back(v);
   endfunction

   initial begin
      logic [7:0] exp036 [5];
      int         seen;
      logic       r;
      logic       l;
      logic       st;

      resetn             = 1'b0;
      bus.load           = 1'b0;
      bus.switches_state = 8'h00;
      bus.stall          = 1'b0;

      // reset and idle
      add(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         add(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      // single push, dequeued the following edge, then bubble
      add(1'b1, 1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 8'h00, 1'b0, 8'h14, 1'b1, 0, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      // five pushes under stall: fill then overflow
      add(1'b1, 1'b1, 8'h31, 1'b1, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 8'h32, 1'b1, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 8'h33, 1'b1, 8'h00, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 8'h34, 1'b1, 8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b1, 8'h35, 1'b1, 8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b1);
      add(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b1);
      // release stall: drain in order, overflow stays sticky
      add(1'b1, 1'b0, 8'h00, 1'b0, 8'h31, 1'b1, 3, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 8'h00, 1'b0, 8'h32, 1'b1, 2, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 1, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 8'h00, 1'b0, 8'h34, 1'b1, 0, 1'b0, 1'b1, 1'b1);
      add(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rn, tbl[i].ld, tbl[i].sw, tbl[i].st);
         chk($sformatf("vec%0d if_id_reg", i), int'(bus.if_id_reg), int'(tbl[i].e_ifid));
         chk($sformatf("vec%0d if_id_valid", i), int'(bus.if_id_valid), int'(tbl[i].e_valid));
         chk($sformatf("vec%0d count", i), int'(bus.count), tbl[i].e_cnt);
         chk($sformatf("vec%0d full", i), int'(bus.full), int'(tbl[i].e_full));
         chk($sformatf("vec%0d empty", i), int'(bus.empty), int'(tbl[i].e_empty));
         chk($sformatf("vec%0d overflow", i), int'(bus.overflow), int'(tbl[i].e_ovf));
      end

      // full queue, pop and push on the same edge
      step(1'b1, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 8'h41 + 8'(i), 1'b1);
         step(1'b1, 1'b0, 8'h00, 1'b1);
      end
      chk("fullpush pre count", int'(bus.count), 4);
      step(1'b1, 1'b1, 8'h45, 1'b0);
      chk("fullpush if_id_reg", int'(bus.if_id_reg), 8'h41);
      chk("fullpush count", int'(bus.count), 4);
      chk("fullpush overflow", int'(bus.overflow), 0);
      exp036 = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h00};
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0);
         chk($sformatf("fullpush drain%0d", i), int'(bus.if_id_reg), int'(exp036[i]));
      end

      // load held high for ten cycles gives one entry
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 8'h1C, 1'b0);
         if (i == 0) chk("hold count after first", int'(bus.count), 1);
         if (bus.if_id_valid) seen++;
      end
      chk("hold dequeues", seen, 1);
      chk("hold final count", int'(bus.count), 0);
      step(1'b1, 1'b0, 8'h00, 1'b0);

      // reset while load rises discards queue and that press
      step(1'b1, 1'b1, 8'h51, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 8'h52, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk("rstload pre count", int'(bus.count), 2);
      step(1'b0, 1'b1, 8'h53, 1'b1);
      chk("rstload count", int'(bus.count), 0);
      chk("rstload if_id_reg", int'(bus.if_id_reg), 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h53, 1'b0);
      chk("rstload no push", int'(bus.count), 0);
      chk("rstload valid", int'(bus.if_id_valid), 0);

      // randomized traffic with alternating stall bias
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 99) != 0);
         l  = ($urandom_range(0, 2) == 0) ? ~bus.load : bus.load;
         st = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         step(r, l, 8'($urandom), st);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries; power of two, 2 to 16.
REQ-002 Parameter WIDTH, default 8, instruction width in bits.
REQ-003 Parameter BUBBLE, default 8'h00, no-op instruction (opcode 3'b000, so no regwrite).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 load  input  1  level from load push-button, already active-high; one push per rising edge.
REQ-007 switches_state  input  WIDTH  instruction to enqueue on a load rising edge.
REQ-008 stall  input  1  decode-stage hold; while 1, no dequeue and if_id_reg holds.
REQ-009 if_id_reg  output  WIDTH  IF/ID pipeline register feeding decode.
REQ-010 if_id_valid  output  1  1 when if_id_reg holds a dequeued instruction, 0 when it holds BUBBLE.
REQ-011 count  output  $clog2(DEPTH)+1  entries currently stored.
REQ-012 full / empty  output  1 each  count==DEPTH / count==0.
REQ-013 overflow  output  1  sticky; set when a push is dropped.

Function
REQ-014 Load edge detect: register load_q; push_req = load & ~load_q, evaluated at each posedge.
REQ-015 Push: on push_req, write switches_state at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-016 Pop: pop_req = ~stall & ~empty.
REQ-017 On pop_req, if_id_reg <= entry at rd_ptr, if_id_valid <= 1, and rd_ptr increments modulo DEPTH.
REQ-018 When ~stall & empty, if_id_reg <= BUBBLE and if_id_valid <= 0.
REQ-019 When stall=1, if_id_reg, if_id_valid and rd_ptr hold their values; pushes are still accepted.
REQ-020 No bypass: an instruction pushed at edge N is dequeued no earlier than edge N+1.
REQ-021 Simultaneous push and pop, not full: both occur; count unchanged.
REQ-022 Push when full and pop_req=1 in the same cycle: both occur; count stays DEPTH.
REQ-023 Push when full and pop_req=0: data dropped, pointers and count unchanged, overflow <= 1.
REQ-024 count: +1 on push only, -1 on pop only, unchanged otherwise; never exceeds DEPTH and never goes negative.
REQ-025 full, empty and count are derived from registered state only; no combinational path from inputs.
REQ-026 Holding load high for many cycles produces exactly one push.

Reset
REQ-027 When resetn=0 at posedge:
 - if_id_reg=BUBBLE, if_id_valid=0
 - wr_ptr=rd_ptr=0, count=0, empty=1, full=0
 - overflow=0
 - load_q=1, so a button already held during reset does not push.
REQ-028 Storage array contents need no reset; unread entries are never visible on if_id_reg.
REQ-029 Reset asserted mid-operation discards all queued entries; a push or pop coincident with reset is ignored.

Structure
REQ-030 The shared CPU package holds:
 - instruction width (8)
 - BUBBLE / NOP encoding
 - opcode constants ADD=3'b001 and INC=3'b011
 - field positions: mode[7], opcode[6:4], rd/rs1[3:2], rs2[1:0].
REQ-031 A single sub-module, edge_detect (clk, resetn, in, rise), is natural and is reusable for the other KEY inputs.
REQ-032 The queue storage and pointers stay inline; no separate FIFO module.

Verification
REQ-033 Reset then three idle cycles -> if_id_reg=8'h00, if_id_valid=0, empty=1, count=0, overflow=0.
REQ-034 switches_state=8'h14, load 0->1 at edge 1, stall=0 -> count=1 after edge 1; if_id_reg=8'h14, if_id_valid=1 after edge 2; BUBBLE after edge 3.
REQ-035 stall=1, push 8'h31, 8'h32, 8'h33, 8'h34, 8'h35 (five rising edges):
 - full=1 and count=4 after the fourth push
 - overflow=1 after the fifth push
 - release stall -> if_id_reg shows 31, 32, 33, 34 on consecutive cycles, then BUBBLE.
REQ-036 Queue full with stall=0 and a push on the same edge -> one entry dequeued and one accepted; count=4, overflow=0.
REQ-037 load held high for 10 cycles with switches_state=8'h1C -> exactly one entry; count=1, then 0 after dequeue.
REQ-038 Two entries queued, resetn=0 for one edge while load rises -> count=0, if_id_reg=8'h00, no entry from that load.
